// File: rtl/ras_stack.sv
// Return address stack: circular LIFO of predicted return addresses.
// The oldest entry is overwritten on overflow; pop/push requests are resolved every clock.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      pc_in,
  output logic [31:0]      pc_top,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] tp, tp_nxt, waddr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic             we;

  // Next-state resolution: flush beats any push/pop combination.
  always_comb begin
    tp_nxt  = tp;
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    we      = 1'b0;
    waddr   = tp;
    if (flush) begin
      tp_nxt  = '0;
      cnt_nxt = '0;
    end else if (push && pop && cnt != '0) begin
      we = 1'b1;
    end else if (push) begin
      tp_nxt = tp + PTR_W'(1);
      waddr  = tp + PTR_W'(1);
      we     = 1'b1;
      if (cnt == CNT_W'(DEPTH)) ovf_nxt = 1'b1;
      else                      cnt_nxt = cnt + CNT_W'(1);
    end else if (pop) begin
      if (cnt != '0) begin
        tp_nxt  = tp - PTR_W'(1);
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        unf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp    <= tp_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // Storage is deliberately not reset; pc_top masks it while empty.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[waddr] <= pc_in;
  end

  assign pc_top    = (cnt == '0) ? 32'hFFFF_FFFF : mem[tp];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/ras_stack.md
# ras_stack

Return address stack storage that serves the RAS control logic in the fetch path. It holds up to DEPTH predicted return addresses in a circular buffer. It accepts push, pop, combined pop+push and flush requests once per clock, and always presents the current top-of-stack address for the controller's return-jump target. On overflow the oldest entry is overwritten, so call chains deeper than DEPTH degrade gracefully rather than stalling.

## Interface
Parameters:
- DEPTH, 8 — number of entries; power of two, 2..64.
- PTR_W, log2(DEPTH) — pointer width; derived, not overridden.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst_n  input  1  — synchronous, active-low reset, sampled on the rising edge of clk.
- flush  input  1  — clear stack (driven by the controller's RAS reset output).
- push  input  1  — write pc_in as the new top.
- pop  input  1  — discard the current top.
- pc_in  input  32  — return address to push.
- pc_top  output  32  — current top entry; 32'hFFFFFFFF when empty.
- empty  output  1  — count == 0.
- full  output  1  — count == DEPTH.
- count  output  PTR_W+1  — valid entries, 0..DEPTH.
- overflow  output  1  — one-cycle pulse: the previous cycle's push overwrote the oldest entry.
- underflow  output  1  — one-cycle pulse: the previous cycle's pop hit an empty stack.

## Operation
State:
- mem[DEPTH] x 32 storage.
- top pointer tp (PTR_W bits) indexing the current top entry.
- count register.
- overflow_q and underflow_q registers.
- Storage entries are not reset. pc_top never exposes them when empty.

Priority each cycle: rst_n low > flush > {push, pop} combination.
- Reset (rst_n=0): tp=0, count=0, overflow=0, underflow=0. Push and pop are ignored.
- flush=1: tp=0, count=0, overflow=0, underflow=0. Push and pop in the same cycle are dropped.
- push only:
  - tp = tp+1 mod DEPTH; mem[tp+1] = pc_in; count = min(count+1, DEPTH).
  - If count was DEPTH: overflow=1 next cycle. The oldest entry is lost and tp wraps over it.
- pop only:
  - If count>0: tp = tp-1 mod DEPTH; count = count-1.
  - If count==0: no state change; underflow=1 next cycle.
- push and pop together (JALR pop-then-push case):
  - If count>0: mem[tp] = pc_in; tp and count unchanged. The top entry is replaced; no overflow or underflow.
  - If count==0: behaves as push only (count becomes 1); no underflow.
- Neither push nor pop: hold. overflow and underflow return to 0.

Outputs:
- pc_top = (count==0) ? 32'hFFFFFFFF : mem[tp]. Combinational from registered state only, never from same-cycle push/pop/pc_in.
- empty, full and count are combinational from the count register.
- overflow and underflow are registered pulses, high for exactly one cycle per offending request.

## Timing
- Update latency is one cycle. A request sampled at edge N is visible on pc_top/count/empty/full immediately after edge N.
- A pop request sees the pre-edge pc_top. The controller uses that value as the jump target in the same cycle the pop is asserted.
- Back-to-back requests are supported every cycle with no bubbles.
- Reset output values: pc_top=32'hFFFFFFFF, empty=1, full=0, count=0, overflow=0, underflow=0.
- Reset or flush asserted mid-sequence takes effect at that edge. All prior contents are treated as invalid thereafter.
- Pointer arithmetic wraps modulo DEPTH. count saturates at DEPTH and never exceeds it or goes below 0.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, release → pc_top=FFFFFFFF, empty=1, count=0, no pulses.
- LIFO order: push 0x100, 0x200, 0x300 on consecutive cycles; then pop 3 cycles → pc_top sequence 0x300, 0x200, 0x100, then FFFFFFFF; count 3→0; empty=1.
- Overflow wrap (DEPTH=8): push 0x1000+4·i for i=0..8 → overflow pulses once after the 9th push; count=8, full=1. Then 8 pops → pc_top 0x1020 down to 0x1004 (0x1000 lost); then empty.
- Underflow: pop on empty → underflow=1 for one cycle; count stays 0; pc_top stays FFFFFFFF. Pop+push with pc_in=0x44 on empty → count=1, pc_top=0x44, no underflow.
- Replace: push 0x10, 0x20; then pop+push with pc_in=0x99 → count=2, pc_top=0x99; one pop → pc_top=0x10.
- Flush/reset priority: push 0xA0, 0xB0; then flush with push=1 and pc_in=0xC0 → count=0, pc_top=FFFFFFFF. Repeat with rst_n=0 plus pop → same result, no underflow pulse.
